// File: rtl/shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// shift_rows_pipe
//
// Pipelined Rijndael ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns.
// The byte permutation is combinational on the input side and is captured into
// stage 1. Stages 2..STAGES are plain register slices. A valid/ready handshake
// on both sides lets the round pipeline stall without dropping beats.
//
// Parameters:
//   NB      state columns (4, 6 or 8)
//   STAGES  register stages, 1..4 (latency in cycles)
//   DATA_W  derived state width, 32*NB (fixed)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat present
//   in_ready   block can accept a beat this cycle
//   in_inv     0 = ShiftRows, 1 = InvShiftRows, travels with the beat
//   in_data    state, row-major, byte 0 at the MSB
//   out_valid  output beat present
//   out_ready  downstream accepts the beat
//   out_inv    mode bit carried alongside the beat
//   out_data   permuted state, row-major
// -----------------------------------------------------------------------------
module shift_rows_pipe #(
    parameter  int NB     = 4,
    parameter  int STAGES = 1,
    localparam int DATA_W = 32 * NB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_inv,
    output logic [DATA_W-1:0] out_data
);

    generate
        if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
            $error("shift_rows_pipe: NB must be 4, 6 or 8");
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("shift_rows_pipe: STAGES must be in 1..4");
        end
    endgenerate

    // Rijndael row offsets: 0,1,2,3 for Nb 4/6; 0,1,3,4 for Nb 8.
    function automatic int row_offset(input int r);
        if (NB == 8)
            return (r < 2) ? r : r + 1;
        else
            return r;
    endfunction

    // ------------------------------------------------------------------
    // Combinational permutation. Both directions are pure wiring; the
    // per-beat mode bit only selects between them.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] fwd_data;
    logic [DATA_W-1:0] inv_data;
    logic [DATA_W-1:0] perm_data;

    genvar gi, gj;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row
            for (gj = 0; gj < NB; gj++) begin : g_col
                localparam int DST     = gi * NB + gj;
                localparam int SRC_FWD = gi * NB + (gj + row_offset(gi)) % NB;
                localparam int SRC_INV = gi * NB + (gj - row_offset(gi) + NB) % NB;
                assign fwd_data[DATA_W-1-8*DST -: 8] = in_data[DATA_W-1-8*SRC_FWD -: 8];
                assign inv_data[DATA_W-1-8*DST -: 8] = in_data[DATA_W-1-8*SRC_INV -: 8];
            end
        end
    endgenerate

    assign perm_data = in_inv ? inv_data : fwd_data;

    // ------------------------------------------------------------------
    // Pipeline registers, stage 1 is closest to the input.
    // ------------------------------------------------------------------
    logic              valid_reg [1:STAGES];
    logic              inv_reg   [1:STAGES];
    logic [DATA_W-1:0] data_reg  [1:STAGES];
    logic [STAGES:1]   load_vec;

    // A stage may load when it is empty or when whatever sits downstream of it
    // can take its current contents. The chain is evaluated from the output
    // back, so a full pipe with out_ready high moves every stage at once and
    // fill/drain happen in the same cycle without a bubble. in_valid never
    // enters this chain.
    always_comb begin : ready_chain
        logic downstream_rdy;
        downstream_rdy = out_ready;
        load_vec       = '0;
        for (int i = STAGES; i >= 1; i--) begin
            load_vec[i]    = !valid_reg[i] || downstream_rdy;
            downstream_rdy = load_vec[i];
        end
    end

    assign in_ready = load_vec[1];

    generate
        for (gi = 1; gi <= STAGES; gi++) begin : g_stage
            logic              up_valid;
            logic              up_inv;
            logic [DATA_W-1:0] up_data;

            if (gi == 1) begin : g_src
                assign up_valid = in_valid;
                assign up_inv   = in_inv;
                assign up_data  = perm_data;
            end else begin : g_src
                assign up_valid = valid_reg[gi-1];
                assign up_inv   = inv_reg[gi-1];
                assign up_data  = data_reg[gi-1];
            end

            // Loading an empty upstream slot clears this stage's valid, which
            // is how a stage empties once it has drained. Payload is only
            // overwritten by a real beat, so a held output never changes.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    inv_reg[gi]   <= 1'b0;
                    data_reg[gi]  <= '0;
                end else if (load_vec[gi]) begin
                    valid_reg[gi] <= up_valid;
                    if (up_valid) begin
                        inv_reg[gi]  <= up_inv;
                        data_reg[gi] <= up_data;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[STAGES];
    assign out_inv   = inv_reg[STAGES];
    assign out_data  = data_reg[STAGES];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// -----------------------------------------------------------------------------
// tb_shift_rows_pipe
//
// Four instances of shift_rows_pipe in different configurations:
//   a: NB=4 STAGES=1    b: NB=8 STAGES=2    c: NB=4 STAGES=3    d: NB=6 STAGES=4
// Every accepted input beat pushes its expected output onto a per-instance
// queue; every emitted output beat pops and compares it. Directed checks cover
// known vectors, latency, stall, reset and round trips.
// -----------------------------------------------------------------------------
module tb_shift_rows_pipe;

    typedef logic [263:0] cw_t;
    typedef struct packed {
        logic         inv;
        logic [255:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    beat_t q [4][$];

    // instance a
    logic a_iv, a_ir, a_ii, a_ov, a_or, a_oi;
    logic [127:0] a_id, a_od;
    // instance b
    logic b_iv, b_ir, b_ii, b_ov, b_or, b_oi;
    logic [255:0] b_id, b_od;
    // instance c
    logic c_iv, c_ir, c_ii, c_ov, c_or, c_oi;
    logic [127:0] c_id, c_od;
    // instance d
    logic d_iv, d_ir, d_ii, d_ov, d_or, d_oi;
    logic [191:0] d_id, d_od;

    shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_inv(a_ii), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_inv(a_oi), .out_data(a_od));
    shift_rows_pipe #(.NB(8), .STAGES(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_inv(b_ii), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_inv(b_oi), .out_data(b_od));
    shift_rows_pipe #(.NB(4), .STAGES(3)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_inv(c_ii), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_inv(c_oi), .out_data(c_od));
    shift_rows_pipe #(.NB(6), .STAGES(4)) u_d (
        .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_ir), .in_inv(d_ii), .in_data(d_id),
        .out_valid(d_ov), .out_ready(d_or), .out_inv(d_oi), .out_data(d_od));

    task automatic check(input string tag, input cw_t obs, input cw_t exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: each row is rotated one byte at a time, offset times.
    function automatic logic [255:0] ref_perm(input int nb, input logic inv, input logic [255:0] d);
        logic [7:0]   row [8];
        logic [7:0]   t;
        logic [255:0] res;
        int           sh;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            if (nb == 8) sh = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 3 : 4;
            else         sh = r;
            for (int c = 0; c < nb; c++) row[c] = d[32*nb-1-8*(r*nb+c) -: 8];
            for (int s = 0; s < sh; s++) begin
                if (!inv) begin
                    t = row[0];
                    for (int c = 0; c < nb - 1; c++) row[c] = row[c+1];
                    row[nb-1] = t;
                end else begin
                    t = row[nb-1];
                    for (int c = nb - 1; c > 0; c--) row[c] = row[c-1];
                    row[0] = t;
                end
            end
            for (int c = 0; c < nb; c++) res[32*nb-1-8*(r*nb+c) -: 8] = row[c];
        end
        return res;
    endfunction

    // Called at the falling edge: anything valid&&ready now transfers on the
    // next rising edge.
    task automatic mon(input int id, input int nb,
                       input logic iv, input logic ir, input logic ii, input logic [255:0] idata,
                       input logic ov, input logic ordy, input logic oi, input logic [255:0] odata);
        beat_t e;
        if (rst) begin
            q[id].delete();
            return;
        end
        if (ov && ordy) begin
            total++;
            assert (q[id].size() != 0) passed++;
            else $error("FAIL dut%0d_spurious_beat observed=%h expected=none", id, odata);
            if (q[id].size() != 0) begin
                e = q[id].pop_front();
                check($sformatf("dut%0d_scoreboard", id), cw_t'({oi, odata}), cw_t'(e));
                $display("dut%0d out inv=%0b data=%h", id, oi, odata);
            end
        end
        if (iv && ir) begin
            e.inv = ii;
            e.d   = ref_perm(nb, ii, idata);
            q[id].push_back(e);
        end
    endtask

    always @(negedge clk) mon(0, 4, a_iv, a_ir, a_ii, 256'(a_id), a_ov, a_or, a_oi, 256'(a_od));
    always @(negedge clk) mon(1, 8, b_iv, b_ir, b_ii, b_id,       b_ov, b_or, b_oi, b_od);
    always @(negedge clk) mon(3, 6, d_iv, d_ir, d_ii, 256'(d_id), d_ov, d_or, d_oi, 256'(d_od));

    // Instance c additionally checks in_ready against beat occupancy and
    // output stability across stalled cycles.
    logic         c_stall_prev = 1'b0;
    logic         c_oi_prev    = 1'b0;
    logic [127:0] c_od_prev    = '0;
    always @(negedge clk) begin
        if (!rst) begin
            check("c_in_ready", cw_t'(c_ir), cw_t'(!(q[2].size() == 3 && !c_or)));
            if (c_stall_prev)
                check("c_stall_hold", cw_t'({c_ov, c_oi, c_od}), cw_t'({1'b1, c_oi_prev, c_od_prev}));
        end
        c_stall_prev = !rst && c_ov && !c_or;
        c_oi_prev    = c_oi;
        c_od_prev    = c_od;
        mon(2, 4, c_iv, c_ir, c_ii, 256'(c_id), c_ov, c_or, c_oi, 256'(c_od));
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic d_beat(input logic inv, input logic [191:0] x, output logic [191:0] y);
        logic got;
        d_iv = 1'b1; d_ii = inv; d_id = x;
        @(posedge clk); #1;
        d_iv = 1'b0;
        y = '0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (d_ov) begin
                y = d_od;
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("d_rt_wait", cw_t'(got), cw_t'(1'b1));
    endtask

    initial begin
        logic [127:0] x128, y128;
        logic [191:0] x192, y192, z192;
        int i, guard, first, cnt;
        logic acc;

        a_iv = 0; a_ii = 0; a_id = '0; a_or = 1;
        b_iv = 0; b_ii = 0; b_id = '0; b_or = 1;
        c_iv = 0; c_ii = 0; c_id = '0; c_or = 1;
        d_iv = 0; d_ii = 0; d_id = '0; d_or = 1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_a", cw_t'({a_ov, a_oi, a_ir, a_od}), cw_t'({3'b001, 128'h0}));
        check("rst_b", cw_t'({b_ov, b_oi, b_ir, b_od}), cw_t'({3'b001, 256'h0}));
        check("rst_c", cw_t'({c_ov, c_oi, c_ir, c_od}), cw_t'({3'b001, 128'h0}));
        check("rst_d", cw_t'({d_ov, d_oi, d_ir, d_od}), cw_t'({3'b001, 192'h0}));

        // Test 1: NB=4 forward
        x128 = 128'h00112233_44556677_8899aabb_ccddeeff;
        a_iv = 1; a_ii = 0; a_id = x128;
        @(posedge clk); #1 a_iv = 0;
        check("t1_fwd", cw_t'({a_ov, a_oi, a_od}), cw_t'({2'b10, 128'h00112233_55667744_aabb8899_ffccddee}));

        // Test 2: NB=4 inverse, then feed back forward
        a_iv = 1; a_ii = 1; a_id = x128;
        @(posedge clk); #1 a_iv = 0;
        check("t2_inv", cw_t'({a_ov, a_oi, a_od}), cw_t'({2'b11, 128'h00112233_77445566_aabb8899_ddeeffcc}));
        y128 = a_od;
        a_iv = 1; a_ii = 0; a_id = y128;
        @(posedge clk); #1 a_iv = 0;
        check("t2_roundtrip", cw_t'({a_ov, a_od}), cw_t'({1'b1, x128}));

        // Test 3: NB=8 forward, bytes 00..1f
        for (int k = 0; k < 32; k++) b_id[255-8*k -: 8] = 8'(k);
        b_iv = 1; b_ii = 0;
        @(posedge clk); #1 b_iv = 0;
        @(posedge clk); #1;
        check("t3_nb8", cw_t'({b_ov, b_oi, b_od}),
              cw_t'({2'b10, 256'h00010203_04050607_090a0b0c_0d0e0f08_13141516_17101112_1c1d1e1f_18191a1b}));
        for (int k = 0; k < 4; k++) begin
            b_iv = 1; b_ii = k[0];
            b_id = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        b_iv = 0;
        repeat (3) @(posedge clk);
        #1;

        // Test 4: NB=4 STAGES=3, 10 beats, random out_ready
        i = 0; guard = 0;
        c_iv = 1; c_ii = 0; c_id = {$urandom, $urandom, $urandom, $urandom};
        c_or = 1'($urandom_range(0, 1));
        while (i < 10 && guard < 1000) begin
            @(negedge clk);
            acc = c_ir;
            @(posedge clk); #1;
            c_or = 1'($urandom_range(0, 1));
            if (acc) begin
                i++;
                if (i < 10) begin
                    c_ii = i[0];
                    c_id = {$urandom, $urandom, $urandom, $urandom};
                end else begin
                    c_iv = 0;
                end
            end
            guard++;
        end
        check("t4_all_accepted", cw_t'(i), cw_t'(10));
        c_iv = 0; c_or = 1;
        guard = 0;
        while (q[2].size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t4_drained", cw_t'(q[2].size()), cw_t'(0));

        // Test 5: NB=8 STAGES=2, fill with out_ready=0, reset mid-operation
        b_or = 0; b_iv = 1; b_ii = 0;
        for (int k = 0; k < 4; k++) begin
            b_id = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        check("t5_full_in_ready", cw_t'({b_ov, b_ir}), cw_t'(2'b10));
        rst = 1; b_id = ~b_id;
        @(posedge clk); #1;
        rst = 0; b_iv = 0;
        check("t5_after_rst", cw_t'({b_ov, b_oi, b_ir, b_od}), cw_t'({3'b001, 256'h0}));
        b_or = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("t5_no_emit", cw_t'(b_ov), cw_t'(1'b0));
        end

        // Test 6: NB=6 STAGES=4, 20 back-to-back beats
        first = -1; cnt = 0;
        d_iv = 1; d_ii = 0; d_id = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int j = 1; j <= 24; j++) begin
            @(posedge clk); #1;
            if (j < 20) begin
                d_ii = j[0];
                d_id = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            end else begin
                d_iv = 0;
            end
            if (d_ov && first < 0) first = j;
            if (d_ov) cnt++;
        end
        check("t6_latency", cw_t'(first), cw_t'(4));
        check("t6_no_bubble", cw_t'(cnt), cw_t'(20));

        for (int k = 0; k < 32; k++) begin
            x192 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            d_beat(1'b0, x192, y192);
            d_beat(1'b1, y192, z192);
            check("t6_roundtrip", cw_t'(z192), cw_t'(x192));
        end

        repeat (6) @(posedge clk);
        #1;
        check("end_q_a", cw_t'(q[0].size()), cw_t'(0));
        check("end_q_b", cw_t'(q[1].size()), cw_t'(0));
        check("end_q_c", cw_t'(q[2].size()), cw_t'(0));
        check("end_q_d", cw_t'(q[3].size()), cw_t'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
Parametrised, pipelined successor to the combinational AES ShiftRows stage. Supports the Rijndael block widths Nb = 4, 6 and 8 columns, and a per-beat mode bit that selects forward ShiftRows (encrypt) or InvShiftRows (decrypt). Sits between SubBytes and MixColumns in the round datapath, with valid/ready handshakes on both sides so the round pipeline can stall.

Parameters:
NB, 4, state columns; legal values 4, 6 or 8; any other value is an elaboration error.
STAGES, 1, register stages; legal range 1..4; sets latency in cycles.
DATA_W, 32*NB, derived state width in bits; not overridable.

Ports:
clk  input  1  clock; all flops rise-edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  input beat present.
in_ready  output  1  block can accept a beat this cycle.
in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows; sampled with the beat.
in_data  input  DATA_W  state, row-major.
out_valid  output  1  output beat present.
out_ready  input  1  downstream accepts the beat.
out_inv  output  1  mode bit carried alongside the beat.
out_data  output  DATA_W  permuted state, row-major.

Behaviour:
- Byte layout: byte k occupies in_data[DATA_W-1-8k -: 8], so byte 0 is at the MSB. Row r (0..3) holds bytes r*NB .. r*NB+NB-1, with column c = k mod NB.
- Row shift offsets C0..C3: 0,1,2,3 when NB is 4 or 6; 0,1,3,4 when NB is 8.
- Forward mode: out row r, col c = in row r, col (c+Cr) mod NB, i.e. a left rotate.
- Inverse mode: out row r, col c = in row r, col (c-Cr+NB) mod NB, i.e. a right rotate.
- The permutation is purely combinational on the input side and is captured into stage 1. Stages 2..STAGES are plain register slices carrying data, inv and valid.
- Latency: a beat accepted at edge t appears on out_data/out_valid after edge t+STAGES-1 (exactly STAGES register stages), given no stall. Throughput is one beat per cycle.
- Handshake:
  - A transfer occurs on an edge where valid && ready on that interface.
  - in_ready = !v[1] || rdy[1], where rdy[i] = !v[i+1] || rdy[i+1] and rdy[STAGES] = out_ready. No combinational path from in_valid to in_ready.
  - Each stage loads when its own ready is high. It clears its valid when it drains and the previous stage is empty.
- Stall: while out_valid=1 and out_ready=0, out_data and out_inv hold stable. Beats are never dropped or duplicated, and order is preserved.
- Mode changes are allowed on every beat. No flush is needed; each beat carries its own inv.
- Reset (synchronous, rst=1 at an edge): all valids go to 0 and all data/inv registers go to 0. Afterwards out_valid=0, out_data=0, out_inv=0, and in_ready=1 from the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded. A beat presented during the reset cycle is not accepted.
- Simultaneous fill and drain on a full pipe: the pipe accepts and emits in the same cycle with no bubble.

Test Plan:
1. NB=4, STAGES=1, inv=0, in_data=0x00112233_44556677_8899aabb_ccddeeff, out_ready=1 -> one cycle later out_data=0x00112233_55667744_aabb8899_ffccddee, out_inv=0.
2. Same data, inv=1 -> out_data=0x00112233_77445566_aabb8899_ddeeffcc. Feeding that result back with inv=0 returns the original state.
3. NB=8, inv=0, in_data bytes 0x00..0x1f in order -> row1=09..0f,08; row2=13,14,15,16,17,10,11,12; row3=1c,1d,1e,1f,18,19,1a,1b; row0 unchanged.
4. NB=4, STAGES=3, 10 back-to-back beats with alternating inv and random out_ready at 50% -> output sequence equals the reference-model sequence in order. out_data is stable during every stalled cycle. in_ready drops only when all 3 stages are full and out_ready=0.
5. STAGES=2, fill the pipe with out_ready=0, then assert rst for 1 cycle -> out_valid=0 and out_data=0 the next cycle, in_ready=1, and no pre-reset beat is ever emitted.
6. NB=6, STAGES=4, continuous in_valid with out_ready=1 for 20 cycles -> first out_valid 4 cycles after the first accept, then one beat per cycle with no bubbles. The round-trip inv=0 then inv=1 returns the input for 32 random states.
